// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - execute-stage branch resolution with compare tracking and return-address register
module branch_unit #(
    parameter int MAX_PEND = 3,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_issue,
    input  logic              cmp_done,
    input  logic [1:0]        cmp_flags,
    output logic              cmp_stall,
    input  logic              kill,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_op,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_target,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] ra_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE} state_t;

    localparam logic [2:0] OP_B    = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BGT  = 3'd2;
    localparam logic [2:0] OP_BLT  = 3'd3;
    localparam logic [2:0] OP_BNE  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;
    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

    state_t              state_q, state_d;
    logic [1:0]          pend_q, pend_d;
    logic [1:0]          flags_q, flags_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   tgt_q, tgt_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;

    logic                accept, resolve, taken, cur_cond;
    logic [2:0]          cur_op;
    logic [ADDR_W-1:0]   cur_pc, cur_tgt, dest;

    assign br_ready       = (state_q == S_IDLE);
    assign cmp_stall      = (pend_q == PEND_MAX);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign ra_out         = ra_q;
    assign accept         = br_valid && br_ready && !kill;

    // A branch resolving straight out of IDLE is decided from the live inputs.
    assign cur_op   = (state_q == S_IDLE) ? br_op     : op_q;
    assign cur_pc   = (state_q == S_IDLE) ? br_pc     : pc_q;
    assign cur_tgt  = (state_q == S_IDLE) ? br_target : tgt_q;
    assign cur_cond = (cur_op == OP_BEQ) || (cur_op == OP_BGT) ||
                      (cur_op == OP_BLT) || (cur_op == OP_BNE);

    always_comb begin
        pend_d = pend_q;
        if (kill) begin
            pend_d = 2'd0;
        end else if (cmp_issue && !cmp_done && pend_q != PEND_MAX) begin
            pend_d = pend_q + 2'd1;
        end else if (cmp_done && !cmp_issue && pend_q != 2'd0) begin
            pend_d = pend_q - 2'd1;
        end
    end

    assign flags_d = cmp_done ? cmp_flags : flags_q;

    always_comb begin
        state_d = state_q;
        resolve = 1'b0;
        op_d    = op_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = br_op;
                    pc_d  = br_pc;
                    tgt_d = br_target;
                    if (cur_cond && pend_d != 2'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESOLVE;
                        resolve = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (pend_d == 2'd0) begin
                    state_d = S_RESOLVE;
                    resolve = 1'b1;
                end
            end
            S_RESOLVE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d = S_IDLE;
            resolve = 1'b0;
        end
    end

    always_comb begin
        taken = 1'b0;
        dest  = cur_tgt;
        case (cur_op)
            OP_B:    taken = 1'b1;
            OP_BEQ:  taken = (flags_d == 2'b01);
            OP_BGT:  taken = (flags_d == 2'b10);
            OP_BLT:  taken = (flags_d == 2'b00);
            OP_BNE:  taken = (flags_d != 2'b01);
            OP_CALL: taken = 1'b1;
            OP_RET: begin
                taken = 1'b1;
                dest  = ra_q;
            end
            default: taken = 1'b0;
        endcase
    end

    // Not-taken branches leave redirect_pc at its last value.
    assign redirect_valid_d = resolve && taken;
    assign redirect_pc_d    = (resolve && taken) ? dest : redirect_pc_q;
    assign ra_d             = (resolve && cur_op == OP_CALL) ? cur_pc + ADDR_W'(1) : ra_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            pend_q           <= 2'd0;
            flags_q          <= 2'b00;
            op_q             <= 3'd0;
            pc_q             <= '0;
            tgt_q            <= '0;
            ra_q             <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            pend_q           <= pend_d;
            flags_q          <= flags_d;
            op_q             <= op_d;
            pc_q             <= pc_d;
            tgt_q            <= tgt_d;
            ra_q             <= ra_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - randomized and directed bench for branch_unit against a transaction-level model
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmp_issue = 1'b0, cmp_done = 1'b0, kill = 1'b0, br_valid = 1'b0;
    logic [1:0]  cmp_flags = 2'b00;
    logic [2:0]  br_op = 3'd0;
    logic [15:0] br_pc = '0, br_target = '0;
    logic        cmp_stall, br_ready, redirect_valid;
    logic [15:0] redirect_pc, ra_out;

    int n_checks = 0;
    int n_errors = 0;

    // Model: outstanding-compare count, last flags, held branch, and the outputs it implies.
    int m_pend, m_flags, m_ra, m_op, m_pc, m_tgt, m_rpc;
    bit m_waiting, m_resolving, m_rv;

    always #5 clk = ~clk;

    branch_unit #(.MAX_PEND(3), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmp_issue(cmp_issue), .cmp_done(cmp_done), .cmp_flags(cmp_flags), .cmp_stall(cmp_stall),
        .kill(kill), .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
        .br_pc(br_pc), .br_target(br_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ra_out(ra_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit outcome(int op, int fl);
        case (op)
            0, 5, 6: return 1'b1;
            1:       return fl == 1;
            2:       return fl == 2;
            3:       return fl == 0;
            4:       return fl != 1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_flags = 0; m_ra = 0; m_op = 0; m_pc = 0; m_tgt = 0; m_rpc = 0;
        m_waiting = 0; m_resolving = 0; m_rv = 0;
    endtask

    task automatic model_resolve(int op, int pc, int tgt);
        if (outcome(op, m_flags)) begin
            m_rv  = 1;
            m_rpc = (op == 6) ? m_ra : tgt;
        end
        if (op == 5) m_ra = (pc + 1) % 65536;
    endtask

    task automatic model_step(bit iss, bit done, int fl, bit kl, bit val, int op, int pc, int tgt);
        int p;
        p = m_pend + int'(iss) - int'(done);
        if (p > 3) p = 3;
        if (p < 0) p = 0;
        m_pend = kl ? 0 : p;
        if (done) m_flags = fl;
        m_rv = 0;
        if (kl) begin
            m_waiting = 0;
            m_resolving = 0;
        end else if (m_resolving) begin
            m_resolving = 0;
        end else if (m_waiting) begin
            if (m_pend == 0) begin
                model_resolve(m_op, m_pc, m_tgt);
                m_waiting = 0;
                m_resolving = 1;
            end
        end else if (val) begin
            if (op >= 1 && op <= 4 && m_pend != 0) begin
                m_op = op; m_pc = pc; m_tgt = tgt;
                m_waiting = 1;
            end else begin
                model_resolve(op, pc, tgt);
                m_resolving = 1;
            end
        end
    endtask

    task automatic check_all();
        check("br_ready", 32'(br_ready), 32'(!(m_waiting || m_resolving)));
        check("cmp_stall", 32'(cmp_stall), 32'(m_pend == 3));
        check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        check("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
        check("ra_out", 32'(ra_out), 32'(m_ra));
    endtask

    // Drive one cycle of inputs from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic tick(bit iss, bit done, logic [1:0] fl, bit kl, bit val,
                        logic [2:0] op, logic [15:0] pc, logic [15:0] tgt);
        cmp_issue = iss; cmp_done = done; cmp_flags = fl; kill = kl;
        br_valid = val; br_op = op; br_pc = pc; br_target = tgt;
        @(posedge clk);
        model_step(iss, done, int'(fl), kl, val, int'(op), int'(pc), int'(tgt));
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(0, 0, 2'b00, 0, 0, 3'd0, 16'h0, 16'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(br_ready), 32'd1);
        check("reset_rv", 32'(redirect_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Unconditional b.
        tick(0, 0, 2'b00, 0, 1, 3'd0, 16'h0010, 16'h0040);
        check("b_rv", 32'(redirect_valid), 32'd1);
        check("b_pc", 32'(redirect_pc), 32'h40);
        check("b_ready", 32'(br_ready), 32'd0);
        idle(1);
        check("b_rv_drop", 32'(redirect_valid), 32'd0);
        check("b_ready_back", 32'(br_ready), 32'd1);

        // beq waiting on a compare, taken then not taken.
        for (int k = 0; k < 2; k++) begin
            tick(1, 0, 2'b00, 0, 0, 3'd0, 16'h0, 16'h0);
            tick(0, 0, 2'b00, 0, 1, 3'd1, 16'h0020, 16'h0100);
            idle(2);
            check("beq_wait", 32'(br_ready | redirect_valid), 32'd0);
            tick(0, 1, (k == 0) ? 2'b01 : 2'b10, 0, 0, 3'd0, 16'h0, 16'h0);
            check("beq_rv", 32'(redirect_valid), (k == 0) ? 32'd1 : 32'd0);
            if (k == 0) check("beq_pc", 32'(redirect_pc), 32'h100);
            idle(1);
            check("beq_idle", 32'(br_ready), 32'd1);
        end

        // Flag conditions with no pending compare; flags arrive with the branch.
        for (int op = 1; op <= 4; op++) begin
            for (int f = 0; f < 4; f++) begin
                tick(0, 1, 2'(f), 0, 1, 3'(op), 16'h0030, 16'h0300 + 16'(op * 4 + f));
                check("flag_cond", 32'(redirect_valid), 32'(outcome(op, f)));
                idle(1);
            end
        end

        // call at 0xFFFF wraps ra, then ret back-to-back.
        tick(0, 0, 2'b00, 0, 1, 3'd5, 16'hFFFF, 16'h2000);
        check("call_pc", 32'(redirect_pc), 32'h2000);
        check("call_ra", 32'(ra_out), 32'h0);
        idle(1);
        tick(0, 0, 2'b00, 0, 1, 3'd6, 16'h2005, 16'h1234);
        check("ret_rv", 32'(redirect_valid), 32'd1);
        check("ret_pc", 32'(redirect_pc), 32'h0);
        idle(1);
        tick(0, 0, 2'b00, 0, 1, 3'd5, 16'h1233, 16'h4000);
        check("call2_ra", 32'(ra_out), 32'h1234);
        idle(1);

        // Counter saturation, simultaneous issue/done, underflow.
        for (int i = 0; i < 4; i++) tick(1, 0, 2'b00, 0, 0, 3'd0, 16'h0, 16'h0);
        check("stall_full", 32'(cmp_stall), 32'd1);
        tick(1, 1, 2'b10, 0, 0, 3'd0, 16'h0, 16'h0);
        check("stall_both", 32'(cmp_stall), 32'd1);
        for (int i = 0; i < 4; i++) tick(0, 1, 2'b00, 0, 0, 3'd0, 16'h0, 16'h0);
        tick(0, 1, 2'b10, 0, 1, 3'd2, 16'h0040, 16'h0500);
        check("underflow_bgt", 32'(redirect_valid), 32'd1);
        idle(1);

        // kill in WAIT, kill with br_valid.
        tick(1, 0, 2'b00, 0, 0, 3'd0, 16'h0, 16'h0);
        tick(1, 0, 2'b00, 0, 1, 3'd4, 16'h0050, 16'h0600);
        tick(0, 0, 2'b00, 1, 0, 3'd0, 16'h0, 16'h0);
        check("kill_idle", 32'(br_ready), 32'd1);
        check("kill_rv", 32'(redirect_valid), 32'd0);
        tick(0, 0, 2'b00, 0, 1, 3'd3, 16'h0060, 16'h0700);
        check("kill_cnt0", 32'(br_ready), 32'd0);
        idle(1);
        tick(0, 0, 2'b00, 1, 1, 3'd0, 16'h0070, 16'h0800);
        check("kill_noacc", 32'(br_ready), 32'd1);
        check("kill_norv", 32'(redirect_valid), 32'd0);

        // Async reset mid-WAIT, between clock edges.
        tick(1, 0, 2'b00, 0, 0, 3'd0, 16'h0, 16'h0);
        tick(0, 0, 2'b00, 0, 1, 3'd1, 16'h0080, 16'h0900);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(br_ready), 32'd1);
        check("arst_rv", 32'(redirect_valid), 32'd0);
        check("arst_pc", 32'(redirect_pc), 32'h0);
        check("arst_ra", 32'(ra_out), 32'h0);
        check("arst_stall", 32'(cmp_stall), 32'd0);
        model_reset();
        cmp_issue = 0; br_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
